// File: rtl/branch_commit_fifo.sv
// Per-branch show-ahead result queue between one execution branch and the commit stage.
// Keeps results in issue order and flags any non-increasing commit_id on push.
module branch_commit_fifo #(
    parameter int data_width = 16,
    parameter int n_blocks   = 256,
    parameter int depth      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(n_blocks)-1:0]  in_block,
    input  logic [2*data_width-1:0]      in_result,
    input  logic [3:0]                   in_dest,
    input  logic [8:0]                   in_commit_id,
    input  logic                         in_commit_flag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(n_blocks)-1:0]  out_block,
    output logic [2*data_width-1:0]      out_result,
    output logic [3:0]                   out_dest,
    output logic [8:0]                   out_commit_id,
    output logic                         out_commit_flag,
    output logic [$clog2(depth):0]       count,
    output logic                         order_error
);

    localparam int BW = $clog2(n_blocks);
    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;
    localparam int EW = BW + 2*data_width + 4 + 9 + 1;

    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(depth);

    logic [EW-1:0] mem_q [depth];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [8:0]    last_id_q, last_id_d;
    logic          last_vld_q, last_vld_d;
    logic          order_err_q, order_err_d;
    logic          push_s, pop_s;
    logic [8:0]    id_diff_s;
    logic [EW-1:0] head_s;

    assign count       = count_q;
    assign order_error = order_err_q;

    // Handshake flags and show-ahead head presentation from registered state only.
    always_comb begin
        in_ready  = ~reset & enable & ~flush & (count_q < CNT_FULL);
        out_valid = ~reset & enable & (count_q != CNT_ZERO);
        push_s    = in_valid & in_ready;
        pop_s     = out_valid & out_ready & ~flush;
        head_s    = mem_q[rd_ptr_q];
        if (out_valid) begin
            {out_block, out_result, out_dest, out_commit_id, out_commit_flag} = head_s;
        end else begin
            {out_block, out_result, out_dest, out_commit_id, out_commit_flag} = {EW{1'b0}};
        end
    end

    // Next-state for pointers, occupancy and the commit-order tracker.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        last_id_d   = last_id_q;
        last_vld_d  = last_vld_q;
        order_err_d = order_err_q;
        // A forward distance of zero or half the id space or more means the id went backwards.
        id_diff_s   = in_commit_id - last_id_q;
        if (flush) begin
            wr_ptr_d   = PTR_ZERO;
            rd_ptr_d   = PTR_ZERO;
            count_d    = CNT_ZERO;
            last_vld_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d   = wr_ptr_q + PTR_ONE;
                last_id_d  = in_commit_id;
                last_vld_d = 1'b1;
                if (last_vld_q && ((id_diff_s == 9'd0) || id_diff_s[8])) begin
                    order_err_d = 1'b1;
                end else begin
                    order_err_d = order_err_q;
                end
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            last_id_q   <= 9'd0;
            last_vld_q  <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_id_q   <= last_id_d;
            last_vld_q  <= last_vld_d;
            order_err_q <= order_err_d;
        end
    end

    // Entry storage; contents need no reset because out_* is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_q[wr_ptr_q] <= {in_block, in_result, in_dest, in_commit_id, in_commit_flag};
        end
    end

endmodule

// File: tb/tb_branch_commit_fifo.sv
// Directed plus randomized bench for branch_commit_fifo, checked against a queue-based model.
module tb_branch_commit_fifo;

    typedef struct {
        logic [7:0]  blk;
        logic [31:0] res;
        logic [3:0]  dest;
        logic [8:0]  id;
        logic        flag;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset, enable, flush, in_valid, in_ready, in_commit_flag;
    logic [7:0]  in_block, out_block;
    logic [31:0] in_result, out_result;
    logic [3:0]  in_dest, out_dest;
    logic [8:0]  in_commit_id, out_commit_id;
    logic        out_valid, out_ready, out_commit_flag, order_error;
    logic [2:0]  count;

    int     checks   = 0;
    int     failures = 0;
    entry_t q[$];
    bit     m_err, m_lv;
    int     m_last;

    branch_commit_fifo #(.data_width(16), .n_blocks(256), .depth(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .in_result(in_result), .in_dest(in_dest), .in_commit_id(in_commit_id),
        .in_commit_flag(in_commit_flag), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .out_result(out_result), .out_dest(out_dest),
        .out_commit_id(out_commit_id), .out_commit_flag(out_commit_flag),
        .count(count), .order_error(order_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare outputs against the model, then advance the model across one clock edge.
    task automatic cycle();
        bit     e_ir, e_ov;
        int     d;
        entry_t h;
        #1;
        e_ir = !reset && enable && !flush && (q.size() < 4);
        e_ov = !reset && enable && (q.size() != 0);
        chk("in_ready", in_ready, e_ir);
        chk("out_valid", out_valid, e_ov);
        chk("count", count, q.size());
        chk("order_error", order_error, m_err);
        if (e_ov) begin
            h = q[0];
            chk("out_commit_id", out_commit_id, h.id);
            chk("out_result", out_result, h.res);
            chk("out_block", out_block, h.blk);
            chk("out_dest", out_dest, h.dest);
            chk("out_flag", out_commit_flag, h.flag);
        end else if (reset) begin
            chk("out_result_rst", out_result, 32'd0);
        end
        if (reset) begin
            q.delete(); m_err = 1'b0; m_lv = 1'b0;
        end else if (flush) begin
            q.delete(); m_lv = 1'b0;
        end else begin
            if (e_ov && out_ready) void'(q.pop_front());
            if (in_valid && e_ir) begin
                d = (int'(in_commit_id) - m_last + 512) % 512;
                if (m_lv && (d == 0 || d >= 256)) m_err = 1'b1;
                m_last = int'(in_commit_id);
                m_lv   = 1'b1;
                q.push_back('{in_block, in_result, in_dest, in_commit_id, in_commit_flag});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [8:0] id, input logic [31:0] res,
                         input bit rdy, input bit fl = 1'b0);
        in_valid       = v;
        in_commit_id   = id;
        in_result      = res;
        in_block       = 8'($urandom);
        in_dest        = 4'($urandom);
        in_commit_flag = 1'($urandom);
        out_ready      = rdy;
        flush          = fl;
        cycle();
    endtask

    initial begin
        logic [8:0] nid;
        bit         v;
        reset = 1'b1; enable = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_block = 8'd0; in_result = 32'd0; in_dest = 4'd0; in_commit_id = 9'd0; in_commit_flag = 1'b0;
        m_err = 1'b0; m_lv = 1'b0; m_last = 0;
        @(posedge clk); @(posedge clk); #1;
        drive(1'b1, 9'd1, 32'h1, 1'b1);
        reset = 1'b0; enable = 1'b1;

        // Ids 3,7,9 held at the head, then drained in order.
        drive(1'b1, 9'd3, 32'hA3, 1'b0);
        drive(1'b1, 9'd7, 32'hA7, 1'b0);
        drive(1'b1, 9'd9, 32'hA9, 1'b0);
        drive(1'b0, 9'd0, 32'h0, 1'b0);
        chk("held_count", count, 32'd3);
        chk("held_head", out_commit_id, 32'd3);
        repeat (4) drive(1'b0, 9'd0, 32'h0, 1'b1);

        // Fill, then pop while full: push must wait one cycle.
        for (int i = 0; i < 4; i++) drive(1'b1, 9'(10 + i), 32'(i), 1'b0);
        chk("full_count", count, 32'd4);
        drive(1'b1, 9'd14, 32'hE, 1'b1);
        chk("after_full_pop", count, 32'd3);
        drive(1'b1, 9'd14, 32'hE, 1'b0);
        chk("fifth_accepted", count, 32'd4);
        repeat (5) drive(1'b0, 9'd0, 32'h0, 1'b1);

        // Single push into an empty queue is visible the next cycle.
        drive(1'b1, 9'd20, 32'h1234ABCD, 1'b0);
        chk("latency_valid", out_valid, 32'd1);
        chk("latency_result", out_result, 32'h1234ABCD);
        drive(1'b0, 9'd0, 32'h0, 1'b1);

        // Steady push+pop across the id wrap 510,511,0,1.
        drive(1'b0, 9'd0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 9'd500, 32'h500, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 9'((500 + i) % 512), 32'($urandom), 1'b1);
            chk("steady_count", count, 32'd1);
        end
        chk("wrap_no_error", order_error, 32'd0);
        drive(1'b0, 9'd0, 32'h0, 1'b1);

        // Repeated id sets the sticky error; flush keeps it, reset clears it.
        drive(1'b0, 9'd0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 9'd20, 32'h20, 1'b1);
        drive(1'b1, 9'd20, 32'h21, 1'b1);
        chk("dup_error", order_error, 32'd1);
        drive(1'b0, 9'd0, 32'h0, 1'b0, 1'b1);
        chk("error_after_flush", order_error, 32'd1);
        reset = 1'b1;
        drive(1'b0, 9'd0, 32'h0, 1'b0);
        reset = 1'b0;
        chk("error_after_reset", order_error, 32'd0);

        // Flush with three queued entries and a simultaneous push.
        drive(1'b1, 9'd30, 32'h30, 1'b0);
        drive(1'b1, 9'd31, 32'h31, 1'b0);
        drive(1'b1, 9'd32, 32'h32, 1'b0);
        drive(1'b1, 9'd33, 32'h33, 1'b1, 1'b1);
        chk("flush_count", count, 32'd0);
        chk("flush_valid", out_valid, 32'd0);

        // Disabled queue holds its contents.
        drive(1'b1, 9'd40, 32'h40, 1'b0);
        drive(1'b1, 9'd41, 32'h41, 1'b0);
        enable = 1'b0;
        drive(1'b1, 9'd42, 32'h42, 1'b1);
        drive(1'b1, 9'd43, 32'h43, 1'b1);
        chk("disabled_count", count, 32'd2);
        enable = 1'b1;
        drive(1'b0, 9'd0, 32'h0, 1'b1);

        // Randomized traffic.
        nid = 9'd50;
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(99) == 0);
            enable = ($urandom_range(9) != 0);
            v      = 1'($urandom);
            if ($urandom_range(19) == 0) nid = 9'($urandom);
            else if (v) nid = nid + 9'($urandom_range(3, 1));
            drive(v, nid, 32'($urandom), ($urandom_range(3) != 0), ($urandom_range(29) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
